// File: rtl/pri_arb_rr.sv
// N-way arbiter, fixed-priority or round-robin, one registered grant held until ack.
// Grant latency is 1 cycle; the grant holds while ack=0, and ack=1 with requests pending gives back-to-back grants.
module pri_arb_rr #(
  parameter int N       = 8,
  parameter int RR_MODE = 0,
  parameter int IW      = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          ack,
  output logic          valid,
  output logic [IW-1:0] index,
  output logic [N-1:0]  gnt
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_nx;
  logic [IW-1:0] idx_q, idx_nx;
  logic [IW-1:0] ptr, ptr_nx;
  logic [IW-1:0] base;
  logic [IW-1:0] win;
  logic [IW-1:0] cidx;
  logic          accept, arb;
  int            c;

  // Scan lowest priority first so the highest-priority hit is the last one written.
  // Fixed mode is a round-robin scan anchored permanently at N-1.
  always_comb begin
    win  = '0;
    c    = 0;
    cidx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      c = int'(base) - i;
      if (c < 0) c = c + N;
      cidx = IW'(c);
      if (req[cidx]) win = cidx;
    end
  end

  always_comb begin
    accept   = (state == GRANT) && ack;
    arb      = (state == IDLE) || ack;
    ptr_nx   = ptr;
    state_nx = state;
    idx_nx   = idx_q;
    if (RR_MODE != 0 && accept)
      ptr_nx = (idx_q == '0) ? IW'(N - 1) : idx_q - IW'(1);
    base = (RR_MODE != 0) ? ptr_nx : IW'(N - 1);
    if (arb) begin
      if (|req) begin
        state_nx = GRANT;
        idx_nx   = win;
      end else begin
        state_nx = IDLE;
        idx_nx   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx_q <= '0;
      ptr   <= IW'(N - 1);
    end else begin
      state <= state_nx;
      idx_q <= idx_nx;
      ptr   <= ptr_nx;
    end
  end

  assign valid = (state == GRANT);
  assign index = idx_q;
  assign gnt   = valid ? (N'(1) << idx_q) : '0;

endmodule

// File: tb/tb_pri_arb_rr.sv
// Drives a fixed-priority and a round-robin arbiter in parallel; a behavioural model
// pushes expected outputs into per-DUT queues that are popped after each clock edge.
module tb_pri_arb_rr;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       ack;
  logic       f_valid, r_valid;
  logic [2:0] f_index, r_index;
  logic [7:0] f_gnt, r_gnt;

  int checks = 0;
  int errors = 0;

  int mv[2];
  int mi[2];
  int mp[2];
  logic [11:0] exp_q[2][$];

  always #5 clk = ~clk;

  pri_arb_rr #(.N(8), .RR_MODE(0)) dut_fix (
    .clk(clk), .rst(rst), .req(req), .ack(ack),
    .valid(f_valid), .index(f_index), .gnt(f_gnt)
  );

  pri_arb_rr #(.N(8), .RR_MODE(1)) dut_rr (
    .clk(clk), .rst(rst), .req(req), .ack(ack),
    .valid(r_valid), .index(r_index), .gnt(r_gnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural reference: priority list walked explicitly from the anchor downwards.
  task automatic model(input logic r, input logic [7:0] rq, input logic a);
    for (int m = 0; m < 2; m++) begin
      if (r) begin
        mv[m] = 0; mi[m] = 0; mp[m] = 7;
      end else if (mv[m] == 0 || a) begin
        int anchor;
        int found;
        if (m == 1 && mv[m] == 1 && a) mp[m] = (mi[m] == 0) ? 7 : mi[m] - 1;
        anchor = (m == 1) ? mp[m] : 7;
        found = -1;
        for (int s = 0; s < 8; s++) begin
          int k;
          k = (anchor + 8 - s) % 8;
          if (found < 0 && rq[k]) found = k;
        end
        if (found >= 0) begin mv[m] = 1; mi[m] = found; end
        else begin mv[m] = 0; mi[m] = 0; end
      end
    end
  endtask

  task automatic step(input logic r, input logic [7:0] rq, input logic a);
    logic [11:0] e;
    @(negedge clk);
    rst = r; req = rq; ack = a;
    model(r, rq, a);
    for (int m = 0; m < 2; m++) begin
      logic [7:0] g;
      g = mv[m] != 0 ? (8'h01 << mi[m]) : 8'h00;
      exp_q[m].push_back({mv[m] != 0, 3'(mi[m]), g});
    end
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      logic       v;
      logic [2:0] ix;
      logic [7:0] g;
      v  = (m == 0) ? f_valid : r_valid;
      ix = (m == 0) ? f_index : r_index;
      g  = (m == 0) ? f_gnt   : r_gnt;
      if (exp_q[m].size() == 0) begin
        chk(m == 0 ? "fix_sb_empty" : "rr_sb_empty", 32'd0, 32'd1);
      end else begin
        e = exp_q[m].pop_front();
        chk(m == 0 ? "fix_valid" : "rr_valid", 32'(v), 32'(e[11]));
        chk(m == 0 ? "fix_index" : "rr_index", 32'(ix), 32'(e[10:8]));
        chk(m == 0 ? "fix_gnt" : "rr_gnt", 32'(g), 32'(e[7:0]));
        chk(m == 0 ? "fix_onehot" : "rr_onehot", 32'($countones(g) <= 1), 32'd1);
      end
    end
  endtask

  initial begin
    rst = 1'b1; req = 8'h00; ack = 1'b0;
    mv[0] = 0; mv[1] = 0; mi[0] = 0; mi[1] = 0; mp[0] = 7; mp[1] = 7;

    step(1'b1, 8'h00, 1'b0);
    step(1'b1, 8'hFF, 1'b1);
    chk("reset_valid", 32'(f_valid | r_valid), 32'd0);
    chk("reset_gnt", 32'(f_gnt | r_gnt), 32'd0);

    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b0);
      chk("idle_valid", 32'(f_valid), 32'd0);
      chk("idle_index", 32'(f_index), 32'd0);
      chk("idle_gnt", 32'(f_gnt), 32'd0);
    end

    step(1'b0, 8'h26, 1'b0);
    chk("fix_first_idx", 32'(f_index), 32'd5);
    chk("fix_first_gnt", 32'(f_gnt), 32'h20);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h01, 1'b0);
      chk("hold_valid", 32'(f_valid), 32'd1);
      chk("hold_idx", 32'(f_index), 32'd5);
      chk("hold_gnt", 32'(f_gnt), 32'h20);
    end

    for (int i = 0; i < 6; i++) begin
      step(1'b0, 8'h81, 1'b1);
      chk("fix_81_idx", 32'(f_index), 32'd7);
      chk("rr_81_valid", 32'(r_valid), 32'd1);
      chk("rr_81_idx", 32'(r_index), (i % 2 == 0) ? 32'd0 : 32'd7);
    end

    step(1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 8'hFF, 1'b1);
      chk("rr_ff_idx", 32'(r_index), (i < 8) ? 32'(7 - i) : 32'd7);
    end
    step(1'b0, 8'hFF, 1'b1);
    step(1'b0, 8'hFF, 1'b1);
    step(1'b1, 8'hFF, 1'b1);
    chk("rr_rst_valid", 32'(r_valid), 32'd0);
    step(1'b0, 8'hFF, 1'b1);
    chk("rr_after_rst_idx", 32'(r_index), 32'd7);

    step(1'b0, 8'h00, 1'b1);
    chk("drop_valid", 32'(r_valid | f_valid), 32'd0);
    chk("drop_gnt", 32'(r_gnt | f_gnt), 32'd0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("idle_ack_valid", 32'(r_valid), 32'd0);
    step(1'b0, 8'h04, 1'b0);
    chk("idle_then_idx", 32'(r_index), 32'd2);

    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 31) == 0), 8'($urandom), ($urandom_range(0, 2) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pri_arb_rr.md
PRI_ARB_RR -- requirements
Module: pri_arb_rr

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning the number of requesters (legal range 2..32).
REQ-002 The block SHALL have parameter RR_MODE, default 0, selecting arbitration: 0 = fixed priority, 1 = round-robin.
REQ-003 The block SHALL have parameter IW, default $clog2(N), giving the index width (derived; not overridden).
REQ-004 Port clk, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port req, input, N bits: request vector, bit k = requester k.
REQ-007 Port ack, input, 1 bit: consumer accepts the current grant.
REQ-008 Port valid, output, 1 bit: a grant is presented.
REQ-009 Port index, output, IW bits: binary index of the granted requester.
REQ-010 Port gnt, output, N bits: one-hot grant, equal to (valid ? 1<<index : 0).

Function
REQ-011 The block SHALL implement two states: IDLE (valid=0) and GRANT (valid=1).
REQ-012 "Arbitrate" SHALL mean: in IDLE, or in GRANT with ack=1, sample req at the clock edge.
REQ-013 On arbitrate with req!=0, the next state SHALL be GRANT, with index = winner(req, ptr_next).
REQ-014 On arbitrate with req==0, the next state SHALL be IDLE, with index forced to 0.
REQ-015 Grant latency SHALL be exactly 1 cycle: req sampled at edge t appears on valid/index after edge t.
REQ-016 In GRANT with ack=0, valid, index and gnt SHALL hold unchanged regardless of req, including if the granted bit deasserts.
REQ-017 ack while in IDLE SHALL be ignored.
REQ-018 GRANT with ack=1 and req!=0 SHALL give back-to-back grants: valid stays 1 and index updates at the same edge.
REQ-019 Fixed mode: winner SHALL be the highest set bit index of req; the pointer is unused.
REQ-020 Round-robin mode: the block SHALL keep an IW-bit pointer ptr, with ptr itself having highest priority and priority descending ptr, ptr-1, ..., 0, N-1, ..., ptr+1 (wrap-around).
REQ-021 Round-robin mode: on acceptance (GRANT and ack=1) of index k, ptr_next SHALL be k-1, and for k=0 ptr_next SHALL wrap to N-1; otherwise ptr_next = ptr.
REQ-022 The winner at an acceptance edge SHALL use ptr_next, so the just-served requester becomes lowest priority.
REQ-023 ptr SHALL always stay within 0..N-1, including when N is not a power of two.
REQ-024 gnt SHALL always be one-hot or zero, and never have more than one bit set.

Reset
REQ-025 While rst=1 at a clock edge, the block SHALL set state=IDLE, valid=0, index=0, gnt=0 and ptr=N-1, ignoring req and ack.
REQ-026 Reset asserted while in GRANT SHALL drop the pending grant without an acceptance; the first arbitration after reset SHALL match fixed priority.
REQ-027 All outputs SHALL be registered or decoded from registers only, with no combinational path from req or ack to outputs.

Verification (N=8)
REQ-028 Reset, then req=8'h00 for 3 cycles -> valid=0, index=0, gnt=0 throughout.
REQ-029 Fixed mode, req=8'b0010_0110 at edge t, ack=0 -> from t+1: valid=1, index=5, gnt=8'h20, held for 4 cycles even after req changes to 8'h01.
REQ-030 Fixed mode, ack=1 every cycle, req=8'h81 constant -> index=7 on every cycle; requester 0 is never granted.
REQ-031 RR mode, ack=1 every cycle, req=8'h81 constant -> index alternates 7,0,7,0 and valid stays 1 (back-to-back).
REQ-032 RR mode, req=8'hFF, ack=1 -> index sequence 7,6,5,...,0,7 (wrap); then assert rst mid-sequence -> next cycle valid=0, and after release the first grant is 7.
REQ-033 GRANT with ack=1 and req=0 at the same edge -> next cycle valid=0, gnt=0; a later ack in IDLE has no effect.
